fetch_queue_stage: RTL and testbench

//   Parametrised, decoupled instruction-fetch stage. Owns the PC and drives a synchronous-read

---
 rtl/fetch_queue_stage_pkg.sv | 20 ++
 rtl/fetch_queue_stage_fifo.sv | 50 +++++
 rtl/fetch_queue_stage.sv | 79 +++++++
 tb/tb_fetch_queue_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// Shared fetch definitions: NOP encoding, PC step and the queued entry layout.
// Decode imports the same package so both sides agree on the entry format.
package fetch_queue_stage_pkg;

    localparam logic [31:0] NOP_WORD        = 32'h3400_0000;  // ori $zero,$zero,0
    localparam logic [31:0] PC_INC          = 32'd4;
    localparam int          ENTRY_W         = 64;
    localparam int          ENTRY_PC_LSB    = 32;
    localparam int          ENTRY_INSTR_LSB = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] p);
        return p & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// Synchronous FIFO for fetched entries; flush beats push/pop, async active-high reset.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Decoupled instruction fetch: owns the PC, drives a 1-cycle-latency ROM and buffers
// {pc, instr} pairs for decode. Redirect flushes everything and restarts fetch.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = NOP_WORD
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [ADDR_WIDTH-1:0]     rom_addr_out,
    input  logic [31:0]               rom_data_in,
    input  logic                      redirect_in,
    input  logic [31:0]               redirect_pc_in,
    input  logic                      out_ready_in,
    output logic                      out_valid_out,
    output logic [31:0]               instr_out,
    output logic [31:0]               pc_out,
    output logic [31:0]               pc_seq_out,
    output logic [$clog2(DEPTH):0]    count_out
);
    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_OCC = (CW + 1)'(DEPTH);

    logic [31:0]  pc, req_pc;
    logic         inflight;
    logic [CW:0]  occ;
    logic         issue, push, pop;
    fetch_entry_t push_entry, head;

    // An in-flight request already owns a slot, so a return never meets a full queue.
    assign occ   = {1'b0, count_out} + {{CW{1'b0}}, inflight};
    assign issue = !redirect_in && (occ < DEPTH_OCC);
    assign push  = inflight && !redirect_in;
    assign pop   = out_valid_out && out_ready_in;

    assign rom_addr_out     = pc[ADDR_WIDTH+1:2];
    assign push_entry.pc    = req_pc;
    assign push_entry.instr = rom_data_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect_in) begin
            pc       <= align_pc(redirect_pc_in);
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + PC_INC;
            req_pc   <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (redirect_in),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .count (count_out)
    );

    assign out_valid_out = (count_out != '0);
    assign instr_out     = out_valid_out ? head.instr : NOP_INSTR;
    assign pc_out        = head.pc;
    assign pc_seq_out    = head.pc + PC_INC;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: expected {pc, instr} stream queued per fetch run.
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] instr, pc_out, pc_seq;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_mis = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fetch_queue_stage #(
        .ADDR_WIDTH (10),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr_out   (rom_addr),
        .rom_data_in    (rom_data),
        .redirect_in    (redirect),
        .redirect_pc_in (redirect_pc),
        .out_ready_in   (out_ready),
        .out_valid_out  (out_valid),
        .instr_out      (instr),
        .pc_out         (pc_out),
        .pc_seq_out     (pc_seq),
        .count_out      (count)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {22'd0, a};
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic start_stream(input logic [31:0] p);
        logic [31:0] q;
        sb.delete();
        for (int k = 0; k < 48; k++) begin
            q = p + 32'(4 * k);
            sb.push_back({q, rom_word(q[11:2])});
        end
    endtask

    // Monitor at the negedge: an entry accepted at the coming edge must match the scoreboard head.
    task automatic step();
        logic [63:0] e;
        if (out_valid && out_ready && !redirect) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_mis++;
                $display("FAIL sb_underflow got pc=%h instr=%h required no entry", pc_out, instr);
            end else begin
                e = sb.pop_front();
                if ({pc_out, instr} !== e) begin
                    n_mis++;
                    $display("FAIL head got pc=%h instr=%h required pc=%h instr=%h",
                             pc_out, instr, e[63:32], e[31:0]);
                end
                n_cmp++;
                if (pc_seq !== pc_out + 32'd4) begin
                    n_mis++;
                    $display("FAIL pc_seq got %h required %h", pc_seq, pc_out + 32'd4);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid got %b required 0", out_valid); end
        n_cmp++; if (instr !== 32'h3400_0000) begin n_mis++; $display("FAIL rst_instr got %h required 34000000", instr); end
        n_cmp++; if (pc_out !== 32'h0) begin n_mis++; $display("FAIL rst_pc got %h required 0", pc_out); end
        n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL rst_count got %0d required 0", count); end
        n_cmp++; if (rom_addr !== 10'h0) begin n_mis++; $display("FAIL rst_addr got %h required 0", rom_addr); end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        start_stream(32'h0);
        out_ready = 1'b1;
        n_cmp++; if (rom_addr !== 10'h0) begin n_mis++; $display("FAIL fill_addr got %h required 0", rom_addr); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL fill_c1_valid got %b required 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || pc_out !== 32'h0 || instr !== 32'h0) begin
            n_mis++; $display("FAIL fill_c2 got v=%b pc=%h instr=%h required v=1 pc=0 instr=0", out_valid, pc_out, instr);
        end
        repeat (8) step();
    endtask

    task automatic test_stall();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        start_stream(32'h0);
        out_ready = 1'b0;
        repeat (10) step();
        n_cmp++; if (count !== 3'd4) begin n_mis++; $display("FAIL stall_count got %0d required 4", count); end
        n_cmp++; if (rom_addr !== 10'd4) begin n_mis++; $display("FAIL stall_addr got %h required 004", rom_addr); end
        n_cmp++; if (pc_out !== 32'h0) begin n_mis++; $display("FAIL stall_head got %h required 0", pc_out); end
        out_ready = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        for (int i = 0; i < 20 && count != 3'd3; i++) step();
        n_cmp++; if (count !== 3'd3) begin n_mis++; $display("FAIL redir_pre_count got %0d required 3", count); end
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        start_stream(32'h100);
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_mis++; $display("FAIL redir_flush got count=%0d v=%b required 0 0", count, out_valid);
        end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL redir_gap got %b required 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || pc_out !== 32'h100) begin
            n_mis++; $display("FAIL redir_first got v=%b pc=%h required 1 00000100", out_valid, pc_out);
        end
        step();
        n_cmp++; if (pc_out !== 32'h104) begin n_mis++; $display("FAIL redir_second got %h required 00000104", pc_out); end
        repeat (4) step();
    endtask

    task automatic test_redirect_pop();
        out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL rpop_pre got %b required 1", out_valid); end
        redirect = 1'b1; redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        start_stream(32'h200);
        for (int i = 0; i < 10 && !out_valid; i++) step();
        n_cmp++; if (out_valid !== 1'b1 || pc_out !== 32'h200) begin
            n_mis++; $display("FAIL rpop_target got v=%b pc=%h required 1 00000200", out_valid, pc_out);
        end
        repeat (4) step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20 && count != 3'd3; i++) step();
        n_cmp++; if (count !== 3'd3) begin n_mis++; $display("FAIL areset_pre got %0d required 3", count); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_mis++; $display("FAIL areset_vc got v=%b count=%0d required 0 0", out_valid, count);
        end
        n_cmp++; if (instr !== 32'h3400_0000 || pc_out !== 32'h0 || rom_addr !== 10'h0) begin
            n_mis++; $display("FAIL areset_out got instr=%h pc=%h addr=%h required 34000000 0 0", instr, pc_out, rom_addr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        start_stream(32'hFFFF_FFF8);
        n_cmp++; if (rom_addr !== 10'h3FE) begin n_mis++; $display("FAIL wrap_a0 got %h required 3fe", rom_addr); end
        step();
        n_cmp++; if (rom_addr !== 10'h3FF) begin n_mis++; $display("FAIL wrap_a1 got %h required 3ff", rom_addr); end
        step();
        n_cmp++; if (rom_addr !== 10'h000 || pc_out !== 32'hFFFF_FFF8) begin
            n_mis++; $display("FAIL wrap_a2 got addr=%h pc=%h required 000 fffffff8", rom_addr, pc_out);
        end
        step();
        n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_mis++; $display("FAIL wrap_p1 got %h required fffffffc", pc_out); end
        step();
        n_cmp++; if (pc_out !== 32'h0 || out_valid !== 1'b1) begin
            n_mis++; $display("FAIL wrap_p2 got v=%b pc=%h required 1 00000000", out_valid, pc_out);
        end
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
